// File: rtl/spi_sprite_loader.sv
// SPI slave loading double-buffered sprite bitmaps/colours; optional status readback under SPI_READBACK_EN.
// Latency: read port 1 clk, SPI bit enters shift reg SYNC_STAGES+1 clk after SCLK edge; no backpressure (SCLK <= clk/8).
module spi_sprite_loader #(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 12,
  parameter int SPRITE_H    = 10,
  parameter int SYNC_STAGES = 2,
  localparam int SW    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int XW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int YW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_cs,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  input  logic          spi_mode,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  input  logic          frame_start,
  input  logic [SW-1:0] pix_sprite,
  input  logic [XW-1:0] pix_x,
  input  logic [YW-1:0] pix_y,
  output logic          pix,
  output logic [5:0]    pix_color,
  output logic          pending
);

  localparam int BYTES = (SPRITE_W * SPRITE_H + 7) / 8;
  localparam int AW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PW    = AW + 3;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_p, sclk_p;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sample_edge;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  rx_byte;
  logic [1:0]  op;
  logic [3:0]  idx;
  logic [AW-1:0] addr;
  logic        bit_clr, cmd_stb, byte_stb, accept;
  logic [SW-1:0] idx_w;
  logic [3:0]  commit_cnt;

  logic [7:0] shd_bmp [NUM_SPRITES][BYTES];
  logic [7:0] act_bmp [NUM_SPRITES][BYTES];
  logic [5:0] shd_col [NUM_SPRITES];
  logic [5:0] act_col [NUM_SPRITES];

  logic [PW-1:0] rd_p;
  logic          rd_ok;
  logic [7:0]    rd_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_p      <= 1'b0;
      sclk_p    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_p      <= cs_s;
      sclk_p    <= sclk_s;
    end
  end

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_fall     = ~cs_s & cs_p;
  assign cs_rise     = cs_s & ~cs_p;
  assign sample_edge = spi_mode ? (~sclk_s & sclk_p) : (sclk_s & ~sclk_p);
  assign rx_byte     = {shreg, mosi_s};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_clr   = 1'b0;
    cmd_stb   = 1'b0;
    byte_stb  = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        state_nxt = CMD;
        bit_clr   = 1'b1;
      end
      CMD: if (sample_edge && bit_cnt == 3'd7) begin
        cmd_stb   = 1'b1;
        state_nxt = DATA;
      end
      DATA: if (sample_edge && bit_cnt == 3'd7) byte_stb = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // CS release aborts everything, including a byte completing this cycle
    if (cs_rise) begin
      state_nxt = IDLE;
      cmd_stb   = 1'b0;
      byte_stb  = 1'b0;
    end
  end

  assign idx_w  = idx[SW-1:0];
  assign accept = byte_stb && !op[1] && ({1'b0, idx} < 5'(NUM_SPRITES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      op         <= '0;
      idx        <= '0;
      addr       <= '0;
      pending    <= 1'b0;
      commit_cnt <= '0;
      shd_bmp    <= '{default: '0};
      act_bmp    <= '{default: '0};
      shd_col    <= '{default: '0};
      act_col    <= '{default: '0};
    end else begin
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (state != IDLE && sample_edge) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= rx_byte[6:0];
      end
      if (cmd_stb) begin
        op   <= rx_byte[7:6];
        idx  <= rx_byte[3:0];
        addr <= '0;
      end
      if (accept && !op[0]) begin
        shd_bmp[idx_w][addr] <= rx_byte;
        addr <= (addr == AW'(BYTES - 1)) ? '0 : addr + 1'b1;
      end
      if (accept && op[0]) shd_col[idx_w] <= rx_byte[5:0];
      // Active bank takes the pre-write shadow; a coincident byte stays pending
      if (frame_start && pending) begin
        act_bmp    <= shd_bmp;
        act_col    <= shd_col;
        commit_cnt <= commit_cnt + 4'd1;
        pending    <= accept;
      end else if (accept) begin
        pending <= 1'b1;
      end
    end
  end

  assign rd_p    = PW'(pix_y * SPRITE_W + pix_x);
  assign rd_ok   = ({1'b0, pix_x} < (XW+1)'(SPRITE_W)) &&
                   ({1'b0, pix_y} < (YW+1)'(SPRITE_H)) &&
                   ({1'b0, pix_sprite} < (SW+1)'(NUM_SPRITES));
  assign rd_byte = act_bmp[pix_sprite][rd_p[PW-1:3]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix       <= 1'b0;
      pix_color <= '0;
    end else if (rd_ok) begin
      pix       <= rd_byte[~rd_p[2:0]];
      pix_color <= act_col[pix_sprite];
    end else begin
      pix       <= 1'b0;
      pix_color <= '0;
    end
  end

`ifdef SPI_READBACK_EN
  logic       shift_edge, tx_load, miso_q, oe;
  logic [7:0] tx_sr;

  assign shift_edge = spi_mode ? (sclk_s & ~sclk_p) : (~sclk_s & sclk_p);
  assign tx_load    = (cmd_stb && rx_byte[7:6] == 2'b10) || (byte_stb && op == 2'b10);
  assign oe         = (state == DATA) && (op == 2'b10);

  // Load at the sampling edge, present one bit on each following opposite edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr  <= '0;
      miso_q <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_sr <= {pending, 3'b000, commit_cnt};
      end else if (shift_edge && state == DATA) begin
        miso_q <= tx_sr[7];
        tx_sr  <= {tx_sr[6:0], 1'b0};
      end
      if (cmd_stb) miso_q <= 1'b0;
    end
  end

  assign spi_miso    = oe & miso_q;
  assign spi_miso_oe = oe;
`else
  assign spi_miso    = 1'b0;
  assign spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sprite_loader.sv
// Directed bench for spi_sprite_loader; readback checks follow SPI_READBACK_EN.
module tb_spi_sprite_loader;

  logic       clk = 1'b0;
  logic       rst_n, spi_cs, spi_sclk, spi_mosi, spi_mode;
  logic       spi_miso, spi_miso_oe, frame_start;
  logic       pix_sprite;
  logic [3:0] pix_x, pix_y;
  logic       pix, pending;
  logic [5:0] pix_color;
  logic [7:0] rx;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_sprite_loader dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_mode(spi_mode), .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe), .frame_start(frame_start),
    .pix_sprite(pix_sprite), .pix_x(pix_x), .pix_y(pix_y),
    .pix(pix), .pix_color(pix_color), .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit = 8 clk; fs_last raises frame_start in the byte-strobe cycle of the last bit
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit fs_last,
                          output logic [7:0] rxd);
    rxd = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!spi_mode) begin
        spi_mosi = tx[7-i];
        tick(4);
        rxd = {rxd[6:0], spi_miso};
        spi_sclk = 1'b1;
      end else begin
        spi_sclk = 1'b1;
        spi_mosi = tx[7-i];
        tick(4);
        rxd = {rxd[6:0], spi_miso};
        spi_sclk = 1'b0;
      end
      if (fs_last && i == nbits - 1) begin
        tick(2);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      if (!spi_mode) spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    spi_bits(b, 8, 1'b0, d);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs = 1'b1;
    tick(6);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
  endtask

  task automatic rd(input logic s, input logic [3:0] x, input logic [3:0] y);
    pix_sprite = s;
    pix_x = x;
    pix_y = y;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_mode = 1'b0;
    frame_start = 1'b0; pix_sprite = 1'b0; pix_x = '0; pix_y = '0;
    tick(3);
    chk("rst_pix", 32'(pix), 0);
    chk("rst_color", 32'(pix_color), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_oe", 32'(spi_miso_oe), 0);
    rst_n = 1'b1;
    tick(2);
    pulse_fs();
    chk("fs_idle_pending", 32'(pending), 0);
    rd(1'b0, 4'd0, 4'd0);
    chk("rst_s0_pix", 32'(pix), 0);
    rd(1'b1, 4'd11, 4'd9);
    chk("rst_s1_pix", 32'(pix), 0);
    chk("rst_s1_color", 32'(pix_color), 0);

    // Mode 0: fill sprite 1 with ones
    cs_low();
    send(8'h01);
    for (int i = 0; i < 15; i++) send(8'hFF);
    cs_high();
    chk("bmp_pending", 32'(pending), 1);
    rd(1'b1, 4'd0, 4'd0);
    chk("pre_commit_pix", 32'(pix), 0);
    pulse_fs();
    chk("commit_pending", 32'(pending), 0);
    rd(1'b0, 4'd0, 4'd0);
    chk("s0_untouched", 32'(pix), 0);
    pix_sprite = 1'b1;
    #1;
    chk("latency_old", 32'(pix), 0);
    tick(1);
    chk("s1_pix_00", 32'(pix), 1);
    rd(1'b1, 4'd11, 4'd9);
    chk("s1_pix_11_9", 32'(pix), 1);
    rd(1'b1, 4'd12, 4'd0);
    chk("x_oob_pix", 32'(pix), 0);
    rd(1'b1, 4'd3, 4'd10);
    chk("y_oob_pix", 32'(pix), 0);

    // Mode 1: colour write, then bitmap write wrapping past the last byte
    spi_mode = 1'b1;
    tick(2);
    cs_low();
    send(8'h40);
    send(8'h3A);
    cs_high();
    chk("col_pending", 32'(pending), 1);
    pulse_fs();
    chk("col_commit_pending", 32'(pending), 0);
    rd(1'b0, 4'd5, 4'd5);
    chk("s0_color", 32'(pix_color), 'h3A);
    rd(1'b1, 4'd5, 4'd5);
    chk("s1_color", 32'(pix_color), 0);
    rd(1'b0, 4'd12, 4'd0);
    chk("x_oob_color", 32'(pix_color), 0);
    cs_low();
    send(8'h00);
    for (int i = 0; i < 16; i++) send(i == 14 ? 8'h01 : (i == 15 ? 8'hC0 : 8'h00));
    cs_high();
    chk("wrap_pending", 32'(pending), 1);

    // Status op: two commits so far plus one pending write
    cs_low();
    send(8'h80);
    spi_bits(8'h00, 8, 1'b0, rx);
`ifdef SPI_READBACK_EN
    chk("status_byte1", 32'(rx), 'h82);
    chk("status_oe", 32'(spi_miso_oe), 1);
    spi_bits(8'h00, 8, 1'b0, rx);
    chk("status_byte2", 32'(rx), 'h82);
`else
    chk("no_rb_oe", 32'(spi_miso_oe), 0);
    chk("no_rb_rx", 32'(rx), 0);
`endif
    cs_high();
    chk("status_oe_off", 32'(spi_miso_oe), 0);
    chk("status_miso_off", 32'(spi_miso), 0);
    chk("status_pending", 32'(pending), 1);
    pulse_fs();
    rd(1'b0, 4'd0, 4'd0);
    chk("wrap_p0", 32'(pix), 1);
    rd(1'b0, 4'd1, 4'd0);
    chk("wrap_p1", 32'(pix), 1);
    rd(1'b0, 4'd2, 4'd0);
    chk("wrap_p2", 32'(pix), 0);
    rd(1'b0, 4'd10, 4'd9);
    chk("last_p118", 32'(pix), 0);
    rd(1'b0, 4'd11, 4'd9);
    chk("last_p119", 32'(pix), 1);

    // Partial byte discarded on CS release
    cs_low();
    send(8'h00);
    send(8'h55);
    spi_bits(8'hFF, 5, 1'b0, rx);
    cs_high();
    chk("partial_pending", 32'(pending), 1);
    pulse_fs();
    rd(1'b0, 4'd0, 4'd0);
    chk("partial_p0", 32'(pix), 0);
    rd(1'b0, 4'd1, 4'd0);
    chk("partial_p1", 32'(pix), 1);
    rd(1'b0, 4'd8, 4'd0);
    chk("partial_p8", 32'(pix), 0);
    rd(1'b0, 4'd11, 4'd9);
    chk("partial_p119", 32'(pix), 1);
    cs_low();
    send(8'h05);
    send(8'hFF);
    cs_high();
    chk("bad_idx_pending", 32'(pending), 0);
    cs_low();
    send(8'hC0);
    send(8'hFF);
    cs_high();
    chk("op11_pending", 32'(pending), 0);

    // frame_start coinciding with a byte strobe
    cs_low();
    send(8'h41);
    send(8'h15);
    cs_high();
    cs_low();
    send(8'h40);
    spi_bits(8'h2A, 8, 1'b1, rx);
    cs_high();
    chk("coinc_pending", 32'(pending), 1);
    rd(1'b1, 4'd0, 4'd0);
    chk("coinc_s1_color", 32'(pix_color), 'h15);
    rd(1'b0, 4'd0, 4'd0);
    chk("coinc_s0_color", 32'(pix_color), 'h3A);
    pulse_fs();
    chk("coinc_commit_pending", 32'(pending), 0);
    rd(1'b0, 4'd0, 4'd0);
    chk("coinc_s0_new", 32'(pix_color), 'h2A);

    // Reset in the middle of a transfer
    cs_low();
    send(8'h41);
    send(8'h3F);
    cs_high();
    cs_low();
    send(8'h80);
    spi_bits(8'h00, 3, 1'b0, rx);
`ifdef SPI_READBACK_EN
    chk("mid_oe", 32'(spi_miso_oe), 1);
`endif
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_pix", 32'(pix), 0);
    chk("mid_rst_color", 32'(pix_color), 0);
    chk("mid_rst_miso", 32'(spi_miso), 0);
    chk("mid_rst_oe", 32'(spi_miso_oe), 0);
    rst_n = 1'b1;
    spi_cs = 1'b1;
    tick(6);
    rd(1'b1, 4'd0, 4'd0);
    chk("post_rst_pix", 32'(pix), 0);
    rd(1'b0, 4'd0, 4'd0);
    chk("post_rst_color", 32'(pix_color), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
